// File: rtl/dsp_slice_arbiter_pkg.sv
// Shared DSP bundle layout, opmode constants and arbiter state encoding.
package dsp_slice_arbiter_pkg;
    localparam int DSP_IN_W  = 92;
    localparam int DSP_OUT_W = 48;
    localparam int ID_W      = 3;

    localparam int OPMODE_LSB = 84;
    localparam int A_LSB      = 66;
    localparam int B_LSB      = 48;
    localparam int C_LSB      = 0;

    // Z=P with X=Y=0: the slice recirculates P, i.e. holds its value.
    localparam logic [7:0] DSP_NOP      = 8'h20;
    localparam logic [7:0] DSP_XIN_MULT = 8'h05;
    localparam logic [7:0] DSP_ZIN_POUT = 8'h20;

    localparam logic [DSP_IN_W-1:0] DSP_NOP_BUNDLE = {DSP_NOP, 84'b0};

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;
endpackage

// File: rtl/dsp_slice_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, then take the lowest set bit.
module rr_pick
    import dsp_slice_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);
    logic [2*N-1:0] dbl_sh;
    logic [N-1:0]   rot;
    logic [ID_W:0]  off;
    logic [ID_W:0]  sum;

    assign dbl_sh = {req, req} >> ptr;
    assign rot    = dbl_sh[N-1:0];

    always_comb begin
        any = 1'b0;
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any = 1'b1;
                off = (ID_W+1)'(j);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (ID_W+1)'(N))
            sum = sum - (ID_W+1)'(N);
        idx = sum[ID_W-1:0];
    end
endmodule

// File: rtl/dsp_slice_arbiter.sv
// Round-robin owner of the shared L/R DSP slice pair with a hold watchdog.
module dsp_slice_arbiter
    import dsp_slice_arbiter_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          rel,
    output logic [N_CLIENTS-1:0]          grant,
    output logic                          busy,
    output logic [ID_W-1:0]               owner_id,
    output logic                          timeout_err,
    output logic [ID_W-1:0]               timeout_id,
    input  logic [N_CLIENTS*DSP_IN_W-1:0] cl_ins_flat_l,
    input  logic [N_CLIENTS*DSP_IN_W-1:0] cl_ins_flat_r,
    output logic [DSP_OUT_W-1:0]          cl_outs_flat_l,
    output logic [DSP_OUT_W-1:0]          cl_outs_flat_r,
    output logic [DSP_IN_W-1:0]           dsp_ins_flat_l,
    output logic [DSP_IN_W-1:0]           dsp_ins_flat_r,
    input  logic [DSP_OUT_W-1:0]          dsp_outs_flat_l,
    input  logic [DSP_OUT_W-1:0]          dsp_outs_flat_r
);
    arb_state_e             state_q, state_n;
    logic [N_CLIENTS-1:0]   grant_n;
    logic                   busy_n, terr_n;
    logic [ID_W-1:0]        owner_n, tid_n, ptr_q, ptr_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   pick_any, own_rel, wd_hit;
    logic [ID_W-1:0]        pick_idx;

    rr_pick #(.N(N_CLIENTS)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // grant is one-hot on the owner, so masking with it selects the owner's bits.
    assign own_rel = (|(rel & grant)) | ~(|(req & grant));
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n = state_q;
        grant_n = grant;
        busy_n  = busy;
        owner_n = owner_id;
        terr_n  = 1'b0;
        tid_n   = timeout_id;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n = ST_OWNED;
                    grant_n = {{(N_CLIENTS-1){1'b0}}, 1'b1} << pick_idx;
                    busy_n  = 1'b1;
                    owner_n = pick_idx;
                    cnt_n   = '0;
                end
            end
            ST_OWNED: begin
                if (own_rel || wd_hit) begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                    owner_n = '0;
                    ptr_n   = (owner_id == ID_W'(N_CLIENTS - 1)) ? '0 : owner_id + 1'b1;
                    if (!own_rel) begin
                        terr_n = 1'b1;
                        tid_n  = owner_id;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            owner_id    <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_n;
            grant       <= grant_n;
            busy        <= busy_n;
            owner_id    <= owner_n;
            timeout_err <= terr_n;
            timeout_id  <= tid_n;
            ptr_q       <= ptr_n;
            cnt_q       <= cnt_n;
        end
    end

    // Slices see only the owner's bundles; NOP otherwise, including straight out of reset.
    always_comb begin
        dsp_ins_flat_l = DSP_NOP_BUNDLE;
        dsp_ins_flat_r = DSP_NOP_BUNDLE;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant[i]) begin
                dsp_ins_flat_l = cl_ins_flat_l[i*DSP_IN_W +: DSP_IN_W];
                dsp_ins_flat_r = cl_ins_flat_r[i*DSP_IN_W +: DSP_IN_W];
            end
        end
    end

    assign cl_outs_flat_l = dsp_outs_flat_l;
    assign cl_outs_flat_r = dsp_outs_flat_r;
endmodule

// File: tb/tb_dsp_slice_arbiter.sv
// Bench for dsp_slice_arbiter: vector table, directed corner sequences, randomized run vs model.
module tb_dsp_slice_arbiter;
    import dsp_slice_arbiter_pkg::*;

    localparam int N = 4;
    localparam int T = 16;
    localparam int W = 92;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req, rel, grant;
    logic                busy, timeout_err;
    logic [2:0]          owner_id, timeout_id;
    logic [N*W-1:0]      cl_ins_flat_l, cl_ins_flat_r;
    logic [47:0]         cl_outs_flat_l, cl_outs_flat_r, p_l, p_r;
    logic [W-1:0]        dsp_ins_flat_l, dsp_ins_flat_r;
    logic [W-1:0]        bun_l [N];
    logic [W-1:0]        bun_r [N];

    dsp_slice_arbiter #(.N_CLIENTS(N), .TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .rel             (rel),
        .grant           (grant),
        .busy            (busy),
        .owner_id        (owner_id),
        .timeout_err     (timeout_err),
        .timeout_id      (timeout_id),
        .cl_ins_flat_l   (cl_ins_flat_l),
        .cl_ins_flat_r   (cl_ins_flat_r),
        .cl_outs_flat_l  (cl_outs_flat_l),
        .cl_outs_flat_r  (cl_outs_flat_r),
        .dsp_ins_flat_l  (dsp_ins_flat_l),
        .dsp_ins_flat_r  (dsp_ins_flat_r),
        .dsp_outs_flat_l (p_l),
        .dsp_outs_flat_r (p_r)
    );

    always #5 clk = ~clk;

    always_comb begin
        cl_ins_flat_l = '0;
        cl_ins_flat_r = '0;
        for (int i = 0; i < N; i++) begin
            cl_ins_flat_l[i*W +: W] = bun_l[i];
            cl_ins_flat_r[i*W +: W] = bun_r[i];
        end
    end

    int   n_vec = 0;
    int   n_bad = 0;
    // Reference model: owner index (-1 = nobody), rotating pointer, cycles held.
    int   m_owner, m_ptr, m_hold, m_tid;
    logic m_terr;
    logic [W-1:0] nop_b;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        m_terr = 1'b0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % N;
                    m_hold  = 0;
                end
            end
        end else if (rel[m_owner] || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_hold == T - 1) begin
            m_terr  = 1'b1;
            m_tid   = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", W'(grant), W'(eg));
        chk("busy", W'(busy), W'(m_owner >= 0));
        chk("owner_id", W'(owner_id), (m_owner >= 0) ? W'(m_owner) : '0);
        chk("timeout_err", W'(timeout_err), W'(m_terr));
        chk("timeout_id", W'(timeout_id), W'(m_tid));
        chk("dsp_ins_l", dsp_ins_flat_l, (m_owner >= 0) ? bun_l[m_owner] : nop_b);
        chk("dsp_ins_r", dsp_ins_flat_r, (m_owner >= 0) ? bun_r[m_owner] : nop_b);
        chk("cl_outs_l", W'(cl_outs_flat_l), W'(p_l));
        chk("cl_outs_r", W'(cl_outs_flat_r), W'(p_r));
    endtask

    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] rl);
        req = rq;
        rel = rl;
        p_l = 48'({$urandom(), $urandom()});
        p_r = 48'({$urandom(), $urandom()});
        @(posedge clk);
        model_step();
        #2;
        check_all();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_terr  = 1'b0;
        m_tid   = 0;
        #1;
        check_all();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic rand_bundles();
        for (int i = 0; i < N; i++) begin
            bun_l[i] = {$urandom(), $urandom(), $urandom()};
            bun_r[i] = {$urandom(), $urandom(), $urandom()};
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] rel;
        logic [N-1:0] grant;
        logic         busy;
        logic [2:0]   owner;
        logic         terr;
    } vec_t;

    vec_t         tbl [11];
    logic [2:0]   order [5];
    logic [W-1:0] want_l;

    initial begin
        nop_b = {DSP_NOP, 84'b0};
        req = '0;
        rel = '0;
        p_l = '0;
        p_r = '0;
        for (int i = 0; i < N; i++) begin
            bun_l[i] = nop_b;
            bun_r[i] = nop_b;
        end
        #2;
        do_reset();

        // Single client: grant one cycle after req, release pulse at cycle 9.
        want_l   = {DSP_XIN_MULT | DSP_ZIN_POUT, 18'h04C48, 18'h01000, 48'h0};
        bun_l[1] = want_l;
        bun_r[1] = {DSP_XIN_MULT, 18'h00011, 18'h00022, 48'h000000000333};
        bun_l[2] = {DSP_NOP, 18'h3FFFA, 18'h0, 48'h0};
        for (int i = 0; i < 9; i++) tbl[i] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 3'd1, 1'b0};
        tbl[9]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].req, tbl[i].rel);
            chk("t1_grant", W'(grant), W'(tbl[i].grant));
            chk("t1_busy", W'(busy), W'(tbl[i].busy));
            chk("t1_owner", W'(owner_id), W'(tbl[i].owner));
            chk("t1_terr", W'(timeout_err), W'(tbl[i].terr));
            chk("t1_dsp_l", dsp_ins_flat_l, tbl[i].busy ? want_l : nop_b);
        end

        // All four requesting: served 0,1,2,3,0 with one idle cycle between grants.
        do_reset();
        rand_bundles();
        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        for (int g = 0; g < 5; g++) begin
            cycle(4'b1111, 4'b0000);
            chk("rr_owner", W'(owner_id), W'(order[g]));
            chk("rr_busy", W'(busy), W'(1'b1));
            for (int h = 0; h < 7; h++) cycle(4'b1111, 4'b0000);
            cycle(4'b1111, 4'(1 << order[g]));
            chk("rr_gap", W'(busy), W'(1'b0));
        end

        // Watchdog: client 3 never releases; client 1 is served after the revoke.
        cycle(4'b1000, 4'b0000);
        chk("wd_owner", W'(owner_id), W'(3'd3));
        for (int h = 0; h < 15; h++) cycle(4'b1010, 4'b0000);
        chk("wd_held", W'(busy), W'(1'b1));
        cycle(4'b1010, 4'b0000);
        chk("wd_terr", W'(timeout_err), W'(1'b1));
        chk("wd_tid", W'(timeout_id), W'(3'd3));
        chk("wd_drop", W'(grant), W'(4'b0000));
        cycle(4'b1010, 4'b0000);
        chk("wd_next", W'(owner_id), W'(3'd1));
        chk("wd_pulse", W'(timeout_err), W'(1'b0));

        // Release on the timeout cycle wins: no error.
        for (int h = 0; h < 15; h++) cycle(4'b1010, 4'b0000);
        cycle(4'b1010, 4'b0010);
        chk("relwd_terr", W'(timeout_err), W'(1'b0));
        chk("relwd_busy", W'(busy), W'(1'b0));

        // Owner drops req without rel.
        cycle(4'b1010, 4'b0000);
        chk("drop_owner", W'(owner_id), W'(3'd3));
        cycle(4'b1010, 4'b0000);
        cycle(4'b0010, 4'b0000);
        chk("drop_busy", W'(busy), W'(1'b0));
        chk("drop_terr", W'(timeout_err), W'(1'b0));

        // Reset mid-grant clears grant and forces NOP without waiting for an edge.
        cycle(4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0000);
        chk("mid_busy", W'(busy), W'(1'b1));
        do_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if (c % 8 == 0) rand_bundles();
            cycle(4'($urandom() & $urandom()),
                  ($urandom_range(7) == 0) ? 4'($urandom()) : 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
